// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl_pkg
//  Purpose  : Shared definitions for the load/store unit controller: access
//             size encodings, memory-lane constant, FSM state enum, default
//             memory depth and the request legality check.
//  Ports    : (package - no ports)
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_ctrl_pkg;

    // Number of 32-bit words in the attached data memory unless overridden.
    localparam int unsigned MEM_DEPTH_DEFAULT = 256;

    // Access size encodings carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // The memory is always accessed as a full word; lanes are handled here.
    localparam logic [1:0] MEM_LS_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_RD_STB  = 3'd2,
        S_CAPTURE = 3'd3,
        S_MERGE   = 3'd4,
        S_WR_STB  = 3'd5,
        S_RESP    = 3'd6
    } state_e;

    // A request is rejected when its size is reserved, it is misaligned for
    // its size, or its word index falls outside the attached memory.
    function automatic logic req_illegal(
        input logic [1:0]  size,
        input logic [31:0] addr,
        input int unsigned depth
    );
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
        if ({2'b00, addr[31:2]} >= 32'(depth)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane
//  Purpose  : Combinational byte/half-word lane logic shared by the load and
//             store paths. Extracts and extends the addressed lane of a word
//             for loads, and merges store data into that lane for stores.
//  Ports    : word_i     - memory word being read or modified
//             data_i     - right-aligned store data
//             addr_lo_i  - byte offset within the word
//             size_i     - access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//             unsigned_i - 1 = zero-extend loads, 0 = sign-extend
//             load_o     - extracted, extended load result
//             merge_o    - word_i with the addressed lane replaced by data_i
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
    import lsu_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] data_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  w_byte_sh;
    logic [4:0]  w_half_sh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane starts at offset*8; half lane only depends on addr[1].
    assign w_byte_sh = {addr_lo_i, 3'b000};
    assign w_half_sh = {addr_lo_i[1], 4'b0000};
    assign w_byte    = word_i[w_byte_sh +: 8];
    assign w_half    = word_i[w_half_sh +: 16];

    always_comb begin
        load_o  = word_i;
        merge_o = word_i;
        case (size_i)
            SZ_BYTE: begin
                load_o                 = {{24{w_byte[7] & ~unsigned_i}}, w_byte};
                merge_o[w_byte_sh +: 8] = data_i[7:0];
            end
            SZ_HALF: begin
                load_o                  = {{16{w_half[15] & ~unsigned_i}}, w_half};
                merge_o[w_half_sh +: 16] = data_i[15:0];
            end
            default: begin
                load_o  = word_i;
                merge_o = data_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Single-outstanding load/store controller in front of a
//             word-wide strobed data memory. Sub-word stores are done as a
//             read-modify-write; loads are lane-extracted and extended.
//  Ports    : clk, rst_n                  - clock, async active-low reset
//             req_*_i / req_ready_o       - request from execute stage
//             mem_addr_o (word index), mem_ls_o, mem_read_flag_o,
//             mem_write_flag_o, mem_wdata_o, mem_rdata_i - data memory
//             wb_valid_o, wb_rd_o, wb_data_o, wb_ready_i  - load writeback
//             st_done_o                   - store completion pulse
//             err_o                       - rejected request pulse
//  Timing   : request accepted at edge N;
//             load     - wb_valid high after edge N+3 (earliest take N+4)
//             word st  - write strobe / st_done after edge N+1
//             sub-word - write strobe / st_done after edge N+4
//             illegal  - err high after edge N, back in IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic [31:0] mem_addr_o,
    output logic [1:0]  mem_ls_o,
    output logic        mem_read_flag_o,
    output logic        mem_write_flag_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ready_i,
    output logic        st_done_o,
    output logic        err_o
);

    state_e      state_q, state_d;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] rdata_q;
    logic [31:0] wr_word_q;
    logic        err_q;

    logic        w_accept;
    logic        w_illegal;
    logic [31:0] w_lane_load;
    logic [31:0] w_lane_merge;

    assign w_accept  = req_valid_i && (state_q == S_IDLE);
    assign w_illegal = req_illegal(req_size_i, req_addr_i, MEM_DEPTH);

    // One lane instance serves both directions: it always looks at the
    // captured memory word, so the load result and the merged store word
    // are both derived from the same registered source.
    lsu_lane u_lane (
        .word_i     (rdata_q),
        .data_i     (wdata_q),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .load_o     (w_lane_load),
        .merge_o    (w_lane_merge)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        req_ready_o      = 1'b0;
        mem_read_flag_o  = 1'b0;
        mem_write_flag_o = 1'b0;
        wb_valid_o       = 1'b0;
        st_done_o        = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (w_accept && !w_illegal) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Full-word stores need no read; everything else reads first.
                if (we_q && (size_q == SZ_WORD)) begin
                    state_d = S_WR_STB;
                end else begin
                    state_d = S_RD_STB;
                end
            end
            S_RD_STB: begin
                mem_read_flag_o = 1'b1;
                state_d         = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = we_q ? S_MERGE : S_RESP;
            end
            S_MERGE: begin
                state_d = S_WR_STB;
            end
            S_WR_STB: begin
                mem_write_flag_o = 1'b1;
                st_done_o        = 1'b1;
                state_d          = S_IDLE;
            end
            S_RESP: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, captured read data and write word
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            size_q    <= SZ_BYTE;
            uns_q     <= 1'b0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rd_q      <= '0;
            rdata_q   <= '0;
            wr_word_q <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= w_accept && w_illegal;
            // Rejected requests are not latched so the memory-facing
            // outputs never move for them.
            if (w_accept && !w_illegal) begin
                addr_q    <= req_addr_i;
                size_q    <= req_size_i;
                uns_q     <= req_unsigned_i;
                we_q      <= req_we_i;
                wdata_q   <= req_wdata_i;
                rd_q      <= req_rd_i;
                wr_word_q <= req_wdata_i;
            end
            if (state_q == S_CAPTURE) begin
                rdata_q <= mem_rdata_i;
            end
            if (state_q == S_MERGE) begin
                wr_word_q <= w_lane_merge;
            end
        end
    end

    assign mem_addr_o  = {2'b00, addr_q[31:2]};
    assign mem_ls_o    = MEM_LS_WORD;
    assign mem_wdata_o = wr_word_q;
    assign wb_rd_o     = rd_q;
    // Result only presented while offered so the bus reads zero otherwise.
    assign wb_data_o   = (state_q == S_RESP) ? w_lane_load : 32'h0;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Self-checking bench for lsu_ctrl with a strobed word memory
//             model, a table of directed requests and hand-written sequences
//             for writeback stall and reset during a read-modify-write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam logic [1:0] K_LOAD  = 2'd0;
    localparam logic [1:0] K_STORE = 2'd1;
    localparam logic [1:0] K_ERR   = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] exp;   // wb_data for loads, mem_wdata at write for stores
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_ls;
    logic        mem_read_flag, mem_write_flag;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_ready, st_done, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic        strobe_viol = 1'b0;
    logic        prev_stb = 1'b0;
    logic [31:0] stb_addr = 32'h0;
    logic [31:0] mem [0:255];
    vec_t        vecs [$];

    lsu_ctrl #(.MEM_DEPTH(256)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_we_i         (req_we),
        .req_size_i       (req_size),
        .req_unsigned_i   (req_unsigned),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .req_rd_i         (req_rd),
        .mem_addr_o       (mem_addr),
        .mem_ls_o         (mem_ls),
        .mem_read_flag_o  (mem_read_flag),
        .mem_write_flag_o (mem_write_flag),
        .mem_wdata_o      (mem_wdata),
        .mem_rdata_i      (mem_rdata),
        .wb_valid_o       (wb_valid),
        .wb_rd_o          (wb_rd),
        .wb_data_o        (wb_data),
        .wb_ready_i       (wb_ready),
        .st_done_o        (st_done),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    // Memory model: samples on the rising edge of each strobe.
    always @(posedge mem_read_flag) begin
        rd_cnt    = rd_cnt + 1;
        stb_addr  = mem_addr;
        mem_rdata = mem[mem_addr[7:0]];
    end
    always @(posedge mem_write_flag) begin
        wr_cnt   = wr_cnt + 1;
        stb_addr = mem_addr;
        mem[mem_addr[7:0]] = mem_wdata;
    end

    // Strobe discipline: never both, never back-to-back, address stable.
    always @(negedge clk) begin
        if (mem_read_flag && mem_write_flag) strobe_viol = 1'b1;
        if ((mem_read_flag || mem_write_flag) && prev_stb) strobe_viol = 1'b1;
        if ((mem_read_flag || mem_write_flag) && (mem_addr != stb_addr)) strobe_viol = 1'b1;
        prev_stb = mem_read_flag || mem_write_flag;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] kind, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic [31:0] exp);
        vec_t v;
        v.kind = kind; v.we = we; v.size = size; v.uns = uns;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.exp = exp;
        return v;
    endfunction

    function automatic int exp_lat(input vec_t v);
        if (v.kind == K_ERR) return 0;
        if (v.kind == K_LOAD) return 3;
        return (v.size == 2'b10) ? 1 : 4;
    endfunction

    task automatic drive(input vec_t v);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        req_rd       = v.rd;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          k;
        int          got;
        int          rd0;
        int          wr0;
        logic        hit;
        logic [31:0] dseen;
        logic [4:0]  rseen;
        rd0 = rd_cnt; wr0 = wr_cnt; strobe_viol = 1'b0;
        dseen = 32'h0; rseen = 5'h0;
        wb_ready = 1'b1;
        drive(v);
        tick();                       // acceptance edge N
        req_valid = 1'b0;
        got = -1; k = 0;
        while (got < 0 && k < 20) begin
            case (v.kind)
                K_LOAD:  hit = wb_valid;
                K_STORE: hit = st_done;
                default: hit = err;
            endcase
            if (hit) begin
                got = k; dseen = (v.kind == K_LOAD) ? wb_data : mem_wdata; rseen = wb_rd;
            end else begin
                tick(); k = k + 1;
            end
        end
        check($sformatf("v%0d_latency", idx), got, exp_lat(v));
        if (v.kind != K_ERR) check($sformatf("v%0d_data", idx), dseen, v.exp);
        if (v.kind == K_LOAD) check($sformatf("v%0d_rd", idx), {27'h0, rseen}, {27'h0, v.rd});
        check($sformatf("v%0d_rd_strobes", idx), rd_cnt - rd0,
              (v.kind == K_LOAD || (v.kind == K_STORE && v.size != 2'b10)) ? 1 : 0);
        check($sformatf("v%0d_wr_strobes", idx), wr_cnt - wr0, (v.kind == K_STORE) ? 1 : 0);
        tick();
        check($sformatf("v%0d_idle_after", idx), {28'h0, req_ready, err, st_done, wb_valid}, 32'h8);
        check($sformatf("v%0d_strobe_rules", idx), {31'h0, strobe_viol}, 32'h0);
    endtask

    initial begin
        logic [31:0] hold_data;
        int          k;
        int          wr0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
        mem[3]   = 32'h80FF_7F01;
        mem[4]   = 32'h0000_0000;
        mem[255] = 32'hCAFE_F00D;
        mem_rdata = 32'h0;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        wb_ready = 1'b1;

        //            kind     we    size   uns   addr          wdata         rd     exp
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b00, 1'b0, 32'h0000_000D, 32'h0,        5'd1,  32'h0000_007F));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b00, 1'b0, 32'h0000_000E, 32'h0,        5'd2,  32'hFFFF_FFFF));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b00, 1'b1, 32'h0000_000F, 32'h0,        5'd3,  32'h0000_0080));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b00, 1'b0, 32'h0000_000C, 32'h0,        5'd4,  32'h0000_0001));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0,        5'd5,  32'hFFFF_80FF));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b01, 1'b1, 32'h0000_000E, 32'h0,        5'd6,  32'h0000_80FF));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b01, 1'b0, 32'h0000_000C, 32'h0,        5'd7,  32'h0000_7F01));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        5'd8,  32'h80FF_7F01));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0,        5'd31, 32'hCAFE_F00D));
        vecs.push_back(mk(K_ERR,   1'b0, 2'b01, 1'b0, 32'h0000_0001, 32'h0,        5'd9,  32'h0));
        vecs.push_back(mk(K_ERR,   1'b0, 2'b10, 1'b0, 32'h0000_0402, 32'h0,        5'd9,  32'h0));
        vecs.push_back(mk(K_ERR,   1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0,        5'd9,  32'h0));
        vecs.push_back(mk(K_ERR,   1'b1, 2'b11, 1'b0, 32'h0000_000C, 32'h0,        5'd9,  32'h0));
        vecs.push_back(mk(K_STORE, 1'b1, 2'b00, 1'b0, 32'h0000_000D, 32'h0000_00AB, 5'd0, 32'h80FF_AB01));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,        5'd10, 32'h80FF_AB01));
        vecs.push_back(mk(K_STORE, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h1234_5678, 5'd0, 32'h1234_5678));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        5'd11, 32'h1234_5678));
        vecs.push_back(mk(K_STORE, 1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h7777_BEEF, 5'd0, 32'hBEEF_5678));
        vecs.push_back(mk(K_LOAD,  1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        5'd12, 32'h0000_BEEF));

        // Reset state while held in reset across clock edges.
        tick(); tick();
        check("reset_ctrl", {26'h0, req_ready, mem_read_flag, mem_write_flag, wb_valid, st_done, err}, 32'h20);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_wb", wb_data | {27'h0, wb_rd}, 32'h0);
        check("mem_ls", {30'h0, mem_ls}, 32'h2);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i], i);
        check("mem_word3", mem[3], 32'h80FF_AB01);
        check("mem_word4", mem[4], 32'hBEEF_5678);

        // Writeback stall: result must hold while wb_ready is low.
        wb_ready = 1'b0;
        drive(mk(K_LOAD, 1'b0, 2'b01, 1'b0, 32'h0000_000E, 32'h0, 5'd13, 32'h0));
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!wb_valid && k < 20) begin tick(); k = k + 1; end
        check("stall_latency", k, 3);
        hold_data = wb_data;
        check("stall_data", hold_data, 32'hFFFF_80FF);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall_hold%0d", c), {wb_data[31:1], wb_data[0] ^ 1'b0}, 32'hFFFF_80FF);
            check($sformatf("stall_flags%0d", c), {30'h0, wb_valid, req_ready}, 32'h2);
        end
        wb_ready = 1'b1;
        tick();
        check("stall_release", {30'h0, wb_valid, req_ready}, 32'h1);

        // Reset during CAPTURE of a sub-word store: the write must never happen.
        wr0 = wr_cnt;
        drive(mk(K_STORE, 1'b1, 2'b00, 1'b0, 32'h0000_000C, 32'h0000_0055, 5'd0, 32'h0));
        tick();
        req_valid = 1'b0;
        tick();
        check("rst_seq_rd_stb", {31'h0, mem_read_flag}, 32'h1);
        tick();                        // now in CAPTURE
        check("rst_seq_capture", {30'h0, mem_read_flag, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_seq_ctrl", {26'h0, req_ready, mem_read_flag, mem_write_flag, wb_valid, st_done, err}, 32'h20);
        check("rst_seq_mem_if", mem_addr | mem_wdata, 32'h0);
        check("rst_seq_wb", wb_data | {27'h0, wb_rd}, 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("rst_seq_no_write", wr_cnt - wr0, 0);
        check("rst_seq_mem", mem[3], 32'h80FF_AB01);
        check("rst_seq_idle", {31'h0, req_ready}, 32'h1);
        run_vec(mk(K_LOAD, 1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 5'd14, 32'h80FF_AB01), 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
